// File: rtl/reg_file_32x16.sv
// rtl/reg_file_32x16.sv - 32 x 16-bit register file, two combinational reads, one synchronous write
//
// Ports:
//   clk   in   1       clock; writes take effect on the rising edge
//   rst   in   1       asynchronous active-high reset; clears every register
//   Ra    in   ADDR_W  read port A address
//   Rb    in   ADDR_W  read port B address
//   Rw    in   ADDR_W  write port address
//   WrEn  in   1       write enable; busW is stored into R[Rw] at the next rising clk
//   busW  in   DATA_W  write data
//   busA  out  DATA_W  R[Ra], combinational
//   busB  out  DATA_W  R[Rb], combinational
module reg_file_32x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  input  logic [ADDR_W-1:0] Rw,
  input  logic              WrEn,
  input  logic [DATA_W-1:0] busW,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  // Next-state: only the addressed register changes, and only when enabled.
  always_comb begin
    regs_d = regs_q;
    if (WrEn) begin
      regs_d[Rw] = busW;
    end
  end

  // Reset has priority over the clock, so writes presented while rst is
  // high are dropped and the array stays cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the stored state: no write-through bypass, so a
  // same-address read shows the old value until the edge commits the write.
  assign busA = regs_q[Ra];
  assign busB = regs_q[Rb];

endmodule

// File: tb/tb_reg_file_32x16.sv
// tb/tb_reg_file_32x16.sv - self-checking bench for reg_file_32x16
module tb_reg_file_32x16;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  Ra = '0;
  logic [4:0]  Rb = '0;
  logic [4:0]  Rw = '0;
  logic        WrEn = 1'b0;
  logic [15:0] busW = '0;
  logic [15:0] busA;
  logic [15:0] busB;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference contents of the register file.
  logic [15:0] model [32];

  reg_file_32x16 dut (
    .clk  (clk),
    .rst  (rst),
    .Ra   (Ra),
    .Rb   (Rb),
    .Rw   (Rw),
    .WrEn (WrEn),
    .busW (busW),
    .busA (busA),
    .busB (busB)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [15:0] data);
    @(negedge clk);
    Rw = addr; busW = data; WrEn = 1'b1;
    @(posedge clk);
    #1;
    WrEn = 1'b0;
    model[addr] = data;
  endtask

  initial begin
    // 1. Reset clear with the clock stopped.
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(31 - i);
      #1;
      check($sformatf("reset_a[%0d]", i), busA, 16'h0000);
      check($sformatf("reset_b[%0d]", 31 - i), busB, 16'h0000);
    end
    clk_en = 1'b1;

    // 2. Basic write/read.
    do_write(5'd1, 16'h0001);
    Ra = 5'd1; Rb = 5'd1; #1;
    check("basic_a1", busA, 16'h0001);
    check("basic_b1", busB, 16'h0001);
    Ra = 5'd2; #1;
    check("basic_a2", busA, 16'h0000);

    // 3. Top register, read-during-write shows old value before the edge.
    @(negedge clk);
    WrEn = 1'b1; Rw = 5'd31; busW = 16'hFFFF; Ra = 5'd31;
    #1 check("rdw_before", busA, 16'h0000);
    @(posedge clk);
    #1 check("rdw_after", busA, 16'hFFFF);
    WrEn = 1'b0;
    model[31] = 16'hFFFF;
    Ra = 5'd1; #1;
    check("r1_kept", busA, 16'h0001);

    // 4. Write-enable gating.
    @(negedge clk);
    WrEn = 1'b0; Rw = 5'd5; busW = 16'hA5A5;
    repeat (3) @(posedge clk);
    #1 Ra = 5'd5; #1;
    check("wren_gate", busA, 16'h0000);

    // 5. Asynchronous reset between edges; write during reset is ignored.
    @(negedge clk);
    Ra = 5'd31; Rb = 5'd1; #1;
    check("pre_rst_a", busA, 16'hFFFF);
    check("pre_rst_b", busB, 16'h0001);
    #1 rst = 1'b1;
    #1;
    check("async_rst_a", busA, 16'h0000);
    check("async_rst_b", busB, 16'h0000);
    WrEn = 1'b1; Rw = 5'd7; busW = 16'h1234; Ra = 5'd7;
    @(posedge clk);
    #1 check("wr_in_rst", busA, 16'h0000);
    @(negedge clk);
    WrEn = 1'b0; rst = 1'b0;
    clear_model();
    #1 check("wr_in_rst_after", busA, 16'h0000);

    // 6. Dual-port independence.
    for (int n = 0; n < 32; n++) do_write(5'(n), 16'(n * 16'h0101));
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(31 - i);
      #1;
      check($sformatf("dual_a[%0d]", i), busA, 16'(i * 257));
      check($sformatf("dual_b[%0d]", 31 - i), busB, 16'((31 - i) * 257));
    end

    // Randomized traffic against the model, with occasional async resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      Ra = 5'($urandom_range(0, 31));
      Rb = 5'($urandom_range(0, 31));
      Rw = 5'($urandom_range(0, 31));
      WrEn = ($urandom_range(0, 3) != 0);
      busW = 16'($urandom);
      #1;
      check("rand_a", busA, model[Ra]);
      check("rand_b", busB, model[Rb]);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        clear_model();
        #1;
        check("rand_rst_a", busA, 16'h0000);
        check("rand_rst_b", busB, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        @(posedge clk);
        if (WrEn) model[Rw] = busW;
        #1;
        check("rand_post_a", busA, model[Ra]);
        check("rand_post_b", busB, model[Rb]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
